// File: rtl/fifo_arb_pkg.sv
// Shared definitions for fifo_push_arbiter: arbiter state encoding, stats counter
// width and the modulo-N index increment used by the round-robin pointer.
package fifo_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam int STATS_W = 16;

  // Modulo-n increment that works for non-power-of-two n.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or after
// start, wrapping from n-1 to 0, and returns it as an index and as a one-hot vector.
module rr_pick #(
  parameter int n     = 4,
  parameter int idx_w = (n > 1) ? $clog2(n) : 1
) (
  input  logic [n-1:0]     req,
  input  logic [idx_w-1:0] start,
  output logic [n-1:0]     onehot,
  output logic [idx_w-1:0] idx
);

  always_comb begin
    int         j;
    logic       found;
    logic [idx_w-1:0] cand;
    // NOTE: every variable written here gets a default first, so no path through
    // the loop can leave a value unassigned and infer a latch.
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int k = 0; k < n; k++) begin
      j = int'(start) + k;
      if (j >= n) j = j - n;
      cand = idx_w'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin write-port arbiter with bounded bursts in front of a single FIFO.
// Optional per-requester push counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int nrOfRequesters = 4,
  parameter int bitWidth       = 32,
  parameter int maxBurst       = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [nrOfRequesters-1:0]          request,
  input  logic [nrOfRequesters*bitWidth-1:0] reqData,
  output logic [nrOfRequesters-1:0]          grant,
  input  logic                               fifoFull,
  output logic                               push,
  output logic [bitWidth-1:0]                pushData
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [nrOfRequesters*STATS_W-1:0]  pushCount
`endif
);

  localparam int IDX_W = $clog2(nrOfRequesters);
  localparam int CNT_W = $clog2(maxBurst + 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [0:0]       state;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] burst_cnt;

  logic [nrOfRequesters-1:0] pick_oh;
  logic [IDX_W-1:0]          pick_idx;
  logic                      hold;
  logic                      blocked;
  logic                      accept;
  logic [CNT_W-1:0]          cnt_next;

  rr_pick #(
    .n     (nrOfRequesters),
    .idx_w (IDX_W)
  ) u_rr_pick (
    .req    (request),
    .start  (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // The owner keeps the port only while it still requests; otherwise search resumes.
  assign hold     = (state == ST_BURST) && request[owner];
  assign blocked  = reset || fifoFull;
  assign cnt_next = burst_cnt + CNT_W'(1);

  always_comb begin
    grant = '0;
    for (int i = 0; i < nrOfRequesters; i++) begin
      if (!blocked) grant[i] = hold ? (owner == IDX_W'(i)) : pick_oh[i];
    end
  end

  assign accept = |(request & grant);
  assign push   = accept;

  // One-hot grant lets the data mux be a plain AND-OR; zero when nothing is granted.
  always_comb begin
    pushData = '0;
    for (int i = 0; i < nrOfRequesters; i++) begin
      if (grant[i]) pushData = pushData | reqData[i*bitWidth +: bitWidth];
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of its neighbours regardless of statement order.
    if (reset) begin
      rr_ptr    <= '0;
      state     <= ST_IDLE;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (!fifoFull) begin
      if (hold) begin
        burst_cnt <= cnt_next;
        if (cnt_next == CNT_W'(maxBurst)) state <= ST_IDLE;
      end else if (accept) begin
        rr_ptr <= IDX_W'(next_index(int'(pick_idx), nrOfRequesters));
        if (maxBurst > 1) begin
          state     <= ST_BURST;
          owner     <= pick_idx;
          burst_cnt <= CNT_W'(1);
        end else begin
          state <= ST_IDLE;
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] push_cnt [nrOfRequesters];

  always_ff @(posedge clock) begin
    for (int i = 0; i < nrOfRequesters; i++) begin
      if (reset) begin
        push_cnt[i] <= '0;
      end else if (grant[i] && request[i] && (push_cnt[i] != {STATS_W{1'b1}})) begin
        push_cnt[i] <= push_cnt[i] + STATS_W'(1);
      end
    end
  end

  always_comb begin
    pushCount = '0;
    for (int i = 0; i < nrOfRequesters; i++) begin
      pushCount[i*STATS_W +: STATS_W] = push_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: three instances (maxBurst 1, 3, 4) share
// clock, reset and data; each scenario drives one instance with hand-computed grants.
module tb_fifo_push_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N*W-1:0] data;
  logic [N-1:0]   req1, req3, req4;
  logic           full1, full3, full4;
  logic [N-1:0]   gnt1, gnt3, gnt4;
  logic           push1, push3, push4;
  logic [W-1:0]   pd1, pd3, pd4;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] cnt1, cnt3, cnt4;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_push_arbiter #(.nrOfRequesters(N), .bitWidth(W), .maxBurst(1)) u_mb1 (
    .clock(clk), .reset(rst), .request(req1), .reqData(data), .grant(gnt1),
    .fifoFull(full1), .push(push1), .pushData(pd1)
`ifdef FIFO_ARB_STATS_EN
    , .pushCount(cnt1)
`endif
  );

  fifo_push_arbiter #(.nrOfRequesters(N), .bitWidth(W), .maxBurst(3)) u_mb3 (
    .clock(clk), .reset(rst), .request(req3), .reqData(data), .grant(gnt3),
    .fifoFull(full3), .push(push3), .pushData(pd3)
`ifdef FIFO_ARB_STATS_EN
    , .pushCount(cnt3)
`endif
  );

  fifo_push_arbiter #(.nrOfRequesters(N), .bitWidth(W), .maxBurst(4)) u_mb4 (
    .clock(clk), .reset(rst), .request(req4), .reqData(data), .grant(gnt4),
    .fifoFull(full4), .push(push4), .pushData(pd4)
`ifdef FIFO_ARB_STATS_EN
    , .pushCount(cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return 32'h1111_1111 * (i + 1);
  endfunction

  function automatic logic [31:0] exp_data(input logic [3:0] oh);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < N; i++) if (oh[i]) d = word_of(i);
    return d;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across two edges, then returns at the start of the first free cycle.
  task automatic do_reset();
    rst  = 1'b1;
    req1 = '0; req3 = '0; req4 = '0;
    full1 = 1'b0; full3 = 1'b0; full4 = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Applies a request vector to the maxBurst=4 instance and checks grant/push/data.
  task automatic step4(input string tag, input logic [3:0] r, input logic f, input logic [3:0] eg);
    req4  = r;
    full4 = f;
    #3;
    check({tag, "_grant"}, 32'(gnt4), 32'(eg));
    check({tag, "_push"}, 32'(push4), 32'(|eg));
    check({tag, "_data"}, pd4, exp_data(eg));
    next_cycle();
  endtask

  logic [3:0] exp1 [5];
  logic [3:0] exp3 [7];

  initial begin
    rst  = 1'b1;
    req1 = '0; req3 = '0; req4 = '0;
    full1 = 1'b0; full3 = 1'b0; full4 = 1'b0;
    for (int i = 0; i < N; i++) data[i*W +: W] = word_of(i);

    // Reset gates the grant even with every requester active.
    next_cycle();
    req1 = 4'b1111;
    req4 = 4'b1111;
    #3;
    check("rst_grant1", 32'(gnt1), 32'h0);
    check("rst_push1", 32'(push1), 32'h0);
    check("rst_data1", pd1, 32'h0);
    check("rst_grant4", 32'(gnt4), 32'h0);
    next_cycle();
    req4 = '0;
    rst  = 1'b0;

    // Pure round-robin.
    exp1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      req1 = 4'b1111;
      #3;
      check($sformatf("rr_grant%0d", k), 32'(gnt1), 32'(exp1[k]));
      check($sformatf("rr_data%0d", k), pd1, exp_data(exp1[k]));
      check($sformatf("rr_push%0d", k), 32'(push1), 32'h1);
      next_cycle();
    end

    // Bursts of three alternating between requesters 0 and 2.
    do_reset();
    exp3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    for (int k = 0; k < 7; k++) begin
      req3 = 4'b0101;
      #3;
      check($sformatf("b3_grant%0d", k), 32'(gnt3), 32'(exp3[k]));
      check($sformatf("b3_data%0d", k), pd3, exp_data(exp3[k]));
      next_cycle();
    end

    // Owner 1 releases after two pushes; requester 3 takes over as the new burst owner.
    do_reset();
    step4("rel_c1", 4'b0010, 1'b0, 4'b0010);
    step4("rel_c2", 4'b0010, 1'b0, 4'b0010);
    step4("rel_c3", 4'b1000, 1'b0, 4'b1000);
    step4("rel_c4", 4'b1010, 1'b0, 4'b1000);
    step4("rel_c5", 4'b1010, 1'b0, 4'b1000);
    step4("rel_c6", 4'b1010, 1'b0, 4'b1000);
    step4("rel_c7", 4'b1010, 1'b0, 4'b0010);

    // Full pauses a burst; the count resumes at 3 so the burst ends after two more pushes.
    do_reset();
    step4("full_c1", 4'b0010, 1'b0, 4'b0010);
    step4("full_c2", 4'b0010, 1'b0, 4'b0010);
    step4("full_c3", 4'b0010, 1'b1, 4'b0000);
    step4("full_c4", 4'b0010, 1'b1, 4'b0000);
    step4("full_c5", 4'b0010, 1'b1, 4'b0000);
    step4("full_c6", 4'b0010, 1'b0, 4'b0010);
    step4("full_c7", 4'b0010, 1'b0, 4'b0010);
    step4("full_c8", 4'b0011, 1'b0, 4'b0001);

    // Reset mid-burst drops the burst and the pointer; search restarts at index 0.
    do_reset();
    step4("mid_c1", 4'b0100, 1'b0, 4'b0100);
    step4("mid_c2", 4'b0100, 1'b0, 4'b0100);
    rst = 1'b1;
    step4("mid_rst", 4'b0100, 1'b0, 4'b0000);
    rst = 1'b0;
    step4("mid_c4", 4'b1100, 1'b0, 4'b0100);
    step4("mid_c5", 4'b1100, 1'b0, 4'b0100);
    step4("mid_c6", 4'b1100, 1'b0, 4'b0100);
    step4("mid_c7", 4'b1100, 1'b0, 4'b0100);
    step4("mid_c8", 4'b1100, 1'b0, 4'b1000);

`ifdef FIFO_ARB_STATS_EN
    // Requester 0 pushes every cycle long enough to saturate its counter.
    do_reset();
    #3;
    check("stats_clear", cnt1[31:0], 32'h0);
    req1 = 4'b0001;
    next_cycle();
    repeat (69999) next_cycle();
    req1 = '0;
    #3;
    check("stats_sat", 32'(cnt1[15:0]), 32'h0000_FFFF);
    check("stats_f1", 32'(cnt1[31:16]), 32'h0);
    check("stats_f23", cnt1[63:32], 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Shares the write port of one `fifo` instance between `nrOfRequesters` producers. Each cycle it picks at most one requester by round-robin, drives `push`/`pushData` into the FIFO and returns a one-hot `grant`. A requester may hold the port for a bounded burst of consecutive pushes. It sits directly in front of the FIFO's `push`, `pushData` and `full` pins.

## Interface
- `nrOfRequesters`, 4: number of producers, 2..16.
- `bitWidth`, 32: data width, equal to the FIFO `bitWidth`.
- `maxBurst`, 4: maximum consecutive pushes by one owner, 1..255; 1 means pure round-robin.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `request`  in  nrOfRequesters  bit i set means requester i has a word.
- `reqData`  in  nrOfRequesters*bitWidth  word of requester i in bits [i*bitWidth +: bitWidth].
- `grant`  out  nrOfRequesters  one-hot or zero; request i is accepted this cycle when `grant[i]` is high.
- `fifoFull`  in  1  connected to the FIFO `full`.
- `push`  out  1  connected to the FIFO `push`.
- `pushData`  out  bitWidth  connected to the FIFO `pushData`.

## Operation
- Registered state:
  - `rrPtr` (index, reset 0).
  - `state` ∈ {IDLE, BURST} (reset IDLE).
  - `owner` (index, reset 0).
  - `burstCnt` ($clog2(maxBurst+1) bits, reset 0).
- Acceptance: `accept = |(request & grant)`; `push = accept`; `pushData = reqData` slice of the granted index, all zeros when there is no grant.
- The grant is always a subset of `request`; it is never issued when `fifoFull`=1 or `reset`=1.
- IDLE, or BURST with `request[owner]`=0 (owner released):
  - Grant the first set `request` bit searching upward from `rrPtr`, wrapping from nrOfRequesters-1 to 0.
  - On accept of index i: `rrPtr` ← (i+1) mod nrOfRequesters.
  - If maxBurst>1: `state` ← BURST, `owner` ← i, `burstCnt` ← 1; otherwise `state` stays IDLE.
  - With no accept, an owner release sends `state` to IDLE.
- BURST with `request[owner]`=1 and `fifoFull`=0:
  - Grant `owner` only.
  - `burstCnt` ← `burstCnt`+1; when the new value equals maxBurst, `state` ← IDLE.
  - `rrPtr` is unchanged, so it already points past the owner.
- `fifoFull`=1: no grant and no state change in any state. A burst is paused, not terminated.
- Index arithmetic is modulo nrOfRequesters and works for non-power-of-two counts. `burstCnt` never exceeds maxBurst.

## Timing
- Grant, push and pushData are combinational from registered state, `request` and `fifoFull`; there is zero latency from request to push.
- Handshake:
  - A requester holds `request` and `reqData` stable until it sees `grant`.
  - The transfer completes at the rising edge of the grant cycle.
  - The requester may deassert or present the next word in the following cycle.
- Full boundary: `fifoFull` is sampled in the same cycle, so a push is never issued into a full FIFO. The word is accepted in the first cycle where `fifoFull`=0.
- Simultaneous requests: exactly one grant per cycle, with fairness bounded by nrOfRequesters × maxBurst cycles of non-full FIFO.
- Reset:
  - Takes effect at the next edge and overrides everything.
  - `grant`=0 and `push`=0 combinationally while `reset`=1.
  - All registers return to their reset values; a burst in progress is dropped.
  - The first cycle after reset arbitrates from index 0.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `pushCount`, nrOfRequesters*16 bits; field i counts accepted pushes of requester i.
  - Each field is a 16-bit counter that saturates at 0xFFFF and is cleared by `reset`.
  - It updates at the edge of the accepting cycle.
- Not defined: the port and counters are absent, and arbitration is identical.

## Structure
- Shared package `fifo_arb_pkg`: the `state` encoding (IDLE=0, BURST=1) and the stats counter width constant (16).
- One sub-module, `rr_pick`: purely combinational; inputs are the request vector and start index, outputs are the one-hot grant and the index of the first set bit at or after start, with wrap-around. It is instantiated once.

## Test plan
- N=4, maxBurst=1, `request`=4'b1111 constant, `fifoFull`=0 → grants 0,1,2,3,0 on consecutive cycles; `pushData` matches each slice.
- maxBurst=3, `request`=4'b0101 constant → grants 0,0,0,2,2,2,0; `burstCnt` returns to IDLE after each third push.
- maxBurst=4, owner 1 drops `request` after 2 pushes while `request[3]`=1 → the same cycle grants 3; `state` is BURST with `owner`=3.
- `fifoFull`=1 for 3 cycles in the middle of a burst with `request`=4'b0010 → `push`=0 and grant=0 during those cycles; the burst then resumes with `burstCnt` continuing from its held value.
- `reset` asserted for 1 cycle during a BURST of owner 2 → `push`=0 that cycle; the next cycle, with `request`=4'b1100, grants 2 (search from rrPtr=0).
- With `FIFO_ARB_STATS_EN`: 70000 accepted pushes from requester 0 → `pushCount[15:0]`=0xFFFF and the other fields are 0.
